// File: rtl/vend_transaction_ctrl_if.sv
// Handshake/bus bundle between the vending front-end controller and its environment.
// master drives selection/coin/cancel requests; slave (the controller) drives the results.
interface vend_transaction_ctrl_if;
  logic       select_valid;
  logic [1:0] sel_in;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;

  logic [1:0] item_select;
  logic [7:0] price;
  logic [7:0] sum_money;
  logic       end_trans;
  logic       coin_reject;
  logic       refund;
  logic [7:0] refund_amount;
  logic       busy;

  modport master (
    output select_valid, sel_in, coin_valid, coin_type, cancel,
    input  item_select, price, sum_money, end_trans, coin_reject, refund, refund_amount, busy
  );

  modport slave (
    input  select_valid, sel_in, coin_valid, coin_type, cancel,
    output item_select, price, sum_money, end_trans, coin_reject, refund, refund_amount, busy
  );
endinterface

// File: rtl/vend_transaction_ctrl.sv
// Vending front-end transaction FSM: latches a selection, accumulates coins, then vends or refunds.
// Optional inactivity auto-refund in COLLECT is built when TRANS_TIMEOUT_EN is defined.
module vend_transaction_ctrl #(
  parameter logic [7:0] PRICE_0 = 8'd15,
  parameter logic [7:0] PRICE_1 = 8'd25,
  parameter logic [7:0] PRICE_2 = 8'd40,
  parameter logic [7:0] PRICE_3 = 8'd60,
  parameter logic [7:0] COIN_0  = 8'd5,
  parameter logic [7:0] COIN_1  = 8'd10,
  parameter logic [7:0] COIN_2  = 8'd20,
  parameter logic [7:0] COIN_3  = 8'd50
`ifdef TRANS_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
`endif
) (
  input logic                    clk,
  input logic                    rst_n,
  vend_transaction_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StRefund} state_e;

  state_e     state_q, state_d;
  logic [1:0] item_q, item_d;
  logic [7:0] price_q, price_d;
  logic [7:0] sum_q, sum_d;
  logic       end_trans_q, end_trans_d;
  logic       coin_reject_q, coin_reject_d;
  logic       refund_q, refund_d;
  logic [7:0] refund_amount_q, refund_amount_d;
  logic       busy_q, busy_d;
  logic [8:0] nsum;

`ifdef TRANS_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_hit;
`endif

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    logic [7:0] v;
    unique case (idx)
      2'd0:    v = PRICE_0;
      2'd1:    v = PRICE_1;
      2'd2:    v = PRICE_2;
      default: v = PRICE_3;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] coin_value(input logic [1:0] idx);
    logic [7:0] v;
    unique case (idx)
      2'd0:    v = COIN_0;
      2'd1:    v = COIN_1;
      2'd2:    v = COIN_2;
      default: v = COIN_3;
    endcase
    return v;
  endfunction

  // 9-bit sum so a coin that would wrap the 8-bit credit is detected and rejected.
  assign nsum = {1'b0, sum_q} + {1'b0, coin_value(bus.coin_type)};

`ifdef TRANS_TIMEOUT_EN
  assign timeout_hit = ((idle_cnt_q + 16'd1) == TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d       = state_q;
    item_d        = item_q;
    price_d       = price_q;
    sum_d         = sum_q;
    coin_reject_d = 1'b0;
`ifdef TRANS_TIMEOUT_EN
    idle_cnt_d    = 16'd0;
`endif

    unique case (state_q)
      StIdle: begin
        coin_reject_d = bus.coin_valid;
        if (bus.select_valid) begin
          item_d  = bus.sel_in;
          price_d = price_of(bus.sel_in);
          sum_d   = 8'd0;
          state_d = StCollect;
        end
      end

      StCollect: begin
        if (bus.cancel) begin
          // Cancel takes priority; a coin arriving alongside it is handed back.
          coin_reject_d = bus.coin_valid;
          state_d       = StRefund;
        end else if (bus.coin_valid) begin
          if (nsum[8]) begin
            coin_reject_d = 1'b1;
          end else begin
            sum_d = nsum[7:0];
            if (nsum[7:0] >= price_q) begin
              state_d = StVend;
            end
          end
        end else if (sum_q >= price_q) begin
          // Only reachable for a zero-priced item.
          state_d = StVend;
        end
`ifdef TRANS_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = StRefund;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
`endif
      end

      StVend: begin
        coin_reject_d = bus.coin_valid;
        sum_d         = 8'd0;
        price_d       = 8'd0;
        state_d       = StIdle;
      end

      StRefund: begin
        coin_reject_d = bus.coin_valid;
        sum_d         = 8'd0;
        state_d       = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Pulses are registered versions of the state being entered, so they align with that state.
    end_trans_d     = (state_d == StVend);
    refund_d        = (state_d == StRefund);
    refund_amount_d = refund_d ? sum_d : 8'd0;
    busy_d          = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      item_q          <= 2'd0;
      price_q         <= 8'd0;
      sum_q           <= 8'd0;
      end_trans_q     <= 1'b0;
      coin_reject_q   <= 1'b0;
      refund_q        <= 1'b0;
      refund_amount_q <= 8'd0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      item_q          <= item_d;
      price_q         <= price_d;
      sum_q           <= sum_d;
      end_trans_q     <= end_trans_d;
      coin_reject_q   <= coin_reject_d;
      refund_q        <= refund_d;
      refund_amount_q <= refund_amount_d;
      busy_q          <= busy_d;
    end
  end

`ifdef TRANS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 16'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign bus.item_select   = item_q;
  assign bus.price         = price_q;
  assign bus.sum_money     = sum_q;
  assign bus.end_trans     = end_trans_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.refund        = refund_q;
  assign bus.refund_amount = refund_amount_q;
  assign bus.busy          = busy_q;

endmodule
